bin_to_bcd_converter: RTL

BIN_TO_BCD_CONVERTER -- requirements
Module: bin_to_bcd_converter

---
 rtl/bin_to_bcd_converter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/bin_to_bcd_converter.sv
// Binary to packed-BCD converter using the sequential double-dabble algorithm.
// One shift per clock, BIN_WIDTH shifts per conversion. Inputs at or above
// 10^DIGITS saturate the result to all nines and raise overflow.
module bin_to_bcd_converter #(
    parameter int unsigned BIN_WIDTH = 27,
    parameter int unsigned DIGITS    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_WIDTH-1:0]  bin,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int unsigned CNT_W = $clog2(BIN_WIDTH + 1);
    localparam int unsigned BCD_W = 4 * DIGITS;
    // Wide enough to hold both the input and 10^DIGITS without truncation.
    localparam int unsigned CMP_W = ((BIN_WIDTH > BCD_W) ? BIN_WIDTH : BCD_W) + 1;

    function automatic logic [CMP_W-1:0] pow10(input int unsigned n);
        logic [CMP_W-1:0] p;
        p = CMP_W'(1);
        for (int unsigned i = 0; i < n; i++) begin
            p = p * CMP_W'(10);
        end
        return p;
    endfunction

    localparam logic [CMP_W-1:0] LIMIT     = pow10(DIGITS);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_WIDTH - 1);
    localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t                      state;
    state_t                      state_next;
    logic [BIN_WIDTH-1:0]        shift_reg;
    logic [BIN_WIDTH-1:0]        shift_next;
    logic [BCD_W-1:0]            scratch;
    logic [BCD_W-1:0]            scratch_adj;
    logic [BCD_W-1:0]            scratch_next;
    logic [BCD_W+BIN_WIDTH-1:0]  combined;
    logic [CNT_W-1:0]            count;
    logic                        ovf_latched;
    logic                        bin_over;
    logic                        accept;
    logic                        last_shift;

    // Overflow condition of the value presented on bin.
    always_comb begin
        bin_over = (CMP_W'(bin) >= LIMIT);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and status outputs.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_shift = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (count == LAST_ITER) begin
                    last_shift = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Double-dabble step: add 3 to digits >= 5, then shift {scratch, binary} left.
    always_comb begin
        scratch_adj = scratch;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (scratch[4*d +: 4] >= 4'd5) begin
                scratch_adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
            end
        end
        combined     = {scratch_adj, shift_reg} << 1;
        scratch_next = combined[BCD_W+BIN_WIDTH-1:BIN_WIDTH];
        shift_next   = combined[BIN_WIDTH-1:0];
    end

    // Datapath: capture on accept, iterate in SHIFT, publish on the final shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg   <= '0;
            scratch     <= '0;
            count       <= '0;
            ovf_latched <= 1'b0;
            bcd         <= '0;
            overflow    <= 1'b0;
        end else if (accept) begin
            shift_reg   <= bin;
            scratch     <= '0;
            count       <= '0;
            ovf_latched <= bin_over;
        end else if (state == SHIFT) begin
            shift_reg <= shift_next;
            scratch   <= scratch_next;
            count     <= count + CNT_W'(1);
            if (last_shift) begin
                bcd      <= ovf_latched ? ALL_NINES : scratch_next;
                overflow <= ovf_latched;
            end
        end
    end

endmodule
